// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states, datapath mux
// selects and the instruction class produced by the opcode classifier.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  // Must stay in step with the immediate generator's select decoding.
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd1;
  localparam logic [1:0] ALU_OP_CMP   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [3:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_OP,
    CLS_OPIMM,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_ILLEGAL
  } instr_cls_e;

  function automatic logic uses_mem(input instr_cls_e cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/multicycle_decode.sv
// Combinational opcode classifier: instruction class, immediate format select and legality.
module multicycle_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output instr_cls_e  cls,
  output logic [2:0]  imm_sel,
  output logic        legal
);

  // Only the opcode field matters here; funct fields are decoded by the ALU control.
  logic unused_instr;
  assign unused_instr = ^instr[31:7];

  always_comb begin
    cls     = CLS_ILLEGAL;
    imm_sel = IMM_I;
    legal   = 1'b1;
    case (instr[6:0])
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  begin cls = CLS_STORE;  imm_sel = IMM_S; end
      OPC_OP:     cls = CLS_OP;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_BRANCH: begin cls = CLS_BRANCH; imm_sel = IMM_B; end
      OPC_JAL:    begin cls = CLS_JAL;    imm_sel = IMM_J; end
      OPC_JALR:   cls = CLS_JALR;
      OPC_LUI:    begin cls = CLS_LUI;    imm_sel = IMM_U; end
      OPC_AUIPC:  begin cls = CLS_AUIPC;  imm_sel = IMM_U; end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM around a shared ALU and one unified memory port.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        br_cond,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        trap,
  output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  instr_cls_e cls;
  logic [2:0] imm_dec;
  logic       legal;

  multicycle_decode u_decode (
    .instr   (instr),
    .cls     (cls),
    .imm_sel (imm_dec),
    .legal   (legal)
  );

  logic waiting, timeout;
  assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
  assign wait_d  = waiting ? wait_q + WAIT_W'(1) : '0;

  // ALU selects by class; held through MEM/WB so an unregistered ALU result stays valid.
  logic [1:0] cls_src_a;
  logic       cls_src_b;
  logic [1:0] cls_alu_op;

  always_comb begin
    cls_src_a  = ALU_A_RS1;
    cls_src_b  = ALU_B_RS2;
    cls_alu_op = ALU_OP_ADD;
    case (cls)
      CLS_OP:              cls_alu_op = ALU_OP_FUNCT;
      CLS_OPIMM:           begin cls_alu_op = ALU_OP_FUNCT; cls_src_b = ALU_B_IMM; end
      CLS_LOAD, CLS_STORE: cls_src_b = ALU_B_IMM;
      CLS_LUI:             begin cls_src_a = ALU_A_ZERO; cls_src_b = ALU_B_IMM; end
      CLS_AUIPC, CLS_JAL:  begin cls_src_a = ALU_A_PC;   cls_src_b = ALU_B_IMM; end
      CLS_JALR:            cls_src_b = ALU_B_IMM;
      CLS_BRANCH:          cls_alu_op = ALU_OP_CMP;
      default:             ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (timeout)        state_d = ST_TRAP;
        else if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (cls)
          CLS_LOAD, CLS_STORE:                state_d = ST_MEM;
          CLS_BRANCH, CLS_JAL, CLS_JALR:      state_d = ST_FETCH;
          CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC: state_d = ST_WB;
          default:                            state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (timeout)        state_d = ST_TRAP;
        else if (mem_ready) state_d = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs are forced low while reset is high so an abandoned instruction writes nothing.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    imm_sel   = IMM_I;
    alu_src_a = ALU_A_RS1;
    alu_src_b = ALU_B_RS2;
    alu_op    = ALU_OP_ADD;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    trap      = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_DECODE: imm_sel = imm_dec;
        ST_EXEC: begin
          imm_sel   = imm_dec;
          alu_src_a = cls_src_a;
          alu_src_b = cls_src_b;
          alu_op    = cls_alu_op;
          case (cls)
            CLS_BRANCH: begin
              retire = 1'b1;
              if (br_cond) begin
                pc_write = 1'b1;
                pc_src   = PC_BRANCH;
              end
            end
            CLS_JAL, CLS_JALR: begin
              reg_write = 1'b1;
              wb_sel    = WB_PC4;
              pc_write  = 1'b1;
              pc_src    = (cls == CLS_JAL) ? PC_BRANCH : PC_JALR;
              retire    = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          imm_sel   = imm_dec;
          alu_src_a = cls_src_a;
          alu_src_b = cls_src_b;
          alu_op    = cls_alu_op;
          mem_req   = 1'b1;
          mem_we    = (cls == CLS_STORE);
          retire    = (cls == CLS_STORE) && mem_ready;
        end
        ST_WB: begin
          imm_sel   = imm_dec;
          alu_src_a = cls_src_a;
          alu_src_b = cls_src_b;
          alu_op    = cls_alu_op;
          reg_write = 1'b1;
          wb_sel    = (cls == CLS_LOAD) ? WB_MEM : WB_ALU;
          retire    = 1'b1;
        end
        ST_TRAP: trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = reset ? ST_FETCH : state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (state_q != ST_TRAP) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = reset ? '0 : cycle_q;
  assign instret_cnt = reset ? '0 : instret_q;
`endif

  // Keeps the helper referenced even though the class case covers memory ops directly.
  logic unused_mem_cls;
  assign unused_mem_cls = uses_mem(cls);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: phase-sequence scoreboard plus literal latency pins.
module tb_multicycle_ctrl;

  localparam int unsigned MemTimeout = 15;
  localparam int PH_R = 0, PH_F = 1, PH_D = 2, PH_E = 3, PH_M = 4, PH_W = 5, PH_T = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        br_cond = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_write, pc_write, alu_src_b, reg_write, retire, trap;
  logic [1:0]  pc_src, alu_src_a, alu_op, wb_sel;
  logic [2:0]  imm_sel, state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
  logic [31:0] m_cyc = 0, m_ret = 0;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .MEM_TIMEOUT (MemTimeout)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .CNT_W       (32)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .br_cond     (br_cond),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .imm_sel     (imm_sel),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .retire      (retire),
    .trap        (trap),
    .state       (state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req, mem_we, ir_write, pc_write;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retire, trap;
  } outs_t;

  outs_t act_o, exp_o;
  assign act_o = {state, mem_req, mem_we, ir_write, pc_write, pc_src, imm_sel, alu_src_a,
                  alu_src_b, alu_op, reg_write, wb_sel, retire, trap};

  bit   exp_vld = 0, exp_rst = 0;
  logic cur_br = 1'b0;
  int   cur_cyc = 0;
  int   n_checks = 0, n_fail = 0;
  int   ret_cyc, trap_cyc, br_cyc, we_cnt, rw_cnt, trap_cnt;
  logic [1:0] rw_wb;
  logic [2:0] st_log [0:63];
  bit   tr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] ins);
    logic [6:0] o = ins[6:0];
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 || o == 7'b0010011 ||
           o == 7'b1100011 || o == 7'b1101111 || o == 7'b1100111 || o == 7'b0110111 ||
           o == 7'b0010111;
  endfunction

  // Expected outputs for one cycle of a given phase of the instruction in the IR.
  function automatic outs_t model(input int ph, input logic [31:0] ins, input logic rdy,
                                  input logic br);
    outs_t o = '0;
    logic [6:0] opc = ins[6:0];
    bit ld = opc == 7'b0000011, st = opc == 7'b0100011, op = opc == 7'b0110011;
    bit opi = opc == 7'b0010011, bra = opc == 7'b1100011, jal = opc == 7'b1101111;
    bit jalr = opc == 7'b1100111, lui = opc == 7'b0110111, aui = opc == 7'b0010111;
    logic [2:0] imm = st ? 3'd1 : bra ? 3'd2 : (lui || aui) ? 3'd3 : jal ? 3'd4 : 3'd0;
    logic [1:0] a   = lui ? 2'd2 : (aui || jal) ? 2'd1 : 2'd0;
    logic       b   = ld || st || opi || lui || aui || jal || jalr;
    logic [1:0] aop = (op || opi) ? 2'd1 : bra ? 2'd2 : 2'd0;
    if (ph == PH_E || ph == PH_M || ph == PH_W) begin
      o.imm_sel = imm; o.alu_src_a = a; o.alu_src_b = b; o.alu_op = aop;
    end
    case (ph)
      PH_F: begin o.state = 3'd0; o.mem_req = 1'b1; o.ir_write = rdy; o.pc_write = rdy; end
      PH_D: begin o.state = 3'd1; o.imm_sel = imm; end
      PH_E: begin
        o.state = 3'd2;
        if (bra) begin o.retire = 1'b1; o.pc_write = br; o.pc_src = br ? 2'd1 : 2'd0; end
        if (jal || jalr) begin
          o.reg_write = 1'b1; o.wb_sel = 2'd2; o.pc_write = 1'b1; o.retire = 1'b1;
          o.pc_src = jal ? 2'd1 : 2'd2;
        end
      end
      PH_M: begin
        o.state = 3'd3; o.mem_req = 1'b1; o.mem_we = st; o.retire = st && rdy;
      end
      PH_W: begin o.state = 3'd4; o.reg_write = 1'b1; o.wb_sel = ld ? 2'd1 : 2'd0; o.retire = 1'b1; end
      PH_T: begin o.state = 3'd7; o.trap = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_vld) begin
      if (cur_cyc == 1) begin
        ret_cyc = 0; trap_cyc = 0; br_cyc = 0; we_cnt = 0; rw_cnt = 0; trap_cnt = 0;
        rw_wb = 2'd0;
      end
      check($sformatf("outputs_cyc%0d", cur_cyc), 64'(act_o), 64'(exp_o));
`ifdef MULTICYCLE_CTRL_PERF_EN
      check("cycle_cnt", 64'(cycle_cnt), exp_rst ? 64'd0 : 64'(m_cyc));
      check("instret_cnt", 64'(instret_cnt), exp_rst ? 64'd0 : 64'(m_ret));
      if (exp_rst) begin
        m_cyc = 0; m_ret = 0;
      end else if (exp_o.state != 3'd7) begin
        m_cyc++;
        if (exp_o.retire) m_ret++;
      end
`endif
      if (cur_cyc < 64) st_log[cur_cyc] = state;
      if (retire && ret_cyc == 0) ret_cyc = cur_cyc;
      if (trap && trap_cyc == 0) trap_cyc = cur_cyc;
      if (trap) trap_cnt++;
      if (pc_write && pc_src == 2'd1 && state == 3'd2) br_cyc = cur_cyc;
      if (mem_we) we_cnt++;
      if (reg_write) begin rw_cnt++; rw_wb = wb_sel; end
    end
  end

  task automatic step(input int ph, input logic rdy);
    cur_cyc++;
    reset     = (ph == PH_R);
    mem_ready = rdy;
    br_cond   = cur_br;
    exp_rst   = (ph == PH_R);
    exp_o     = model(ph, instr, rdy, cur_br);
    exp_vld   = 1;
    @(posedge clk);
    #1;
  endtask

  // Expands one instruction into its phase sequence given fetch/memory wait counts.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           output bit trapped);
    logic [6:0] opc = ins[6:0];
    trapped = 0;
    cur_cyc = 0;
    for (int i = 0; i < fw; i++) begin
      step(PH_F, 1'b0);
      if (MemTimeout != 0 && i + 1 == MemTimeout) begin trapped = 1; return; end
    end
    step(PH_F, 1'b1);
    instr = ins;
    step(PH_D, 1'b1);
    if (!is_legal(ins)) begin trapped = 1; return; end
    step(PH_E, 1'b1);
    if (opc == 7'b0000011 || opc == 7'b0100011) begin
      for (int i = 0; i < mw; i++) begin
        step(PH_M, 1'b0);
        if (MemTimeout != 0 && i + 1 == MemTimeout) begin trapped = 1; return; end
      end
      step(PH_M, 1'b1);
      if (opc == 7'b0000011) step(PH_W, 1'b1);
    end else if (opc == 7'b0110011 || opc == 7'b0010011 || opc == 7'b0110111 ||
                 opc == 7'b0010111) begin
      step(PH_W, 1'b1);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    cur_cyc = 0;
    step(PH_R, 1'b1);
    step(PH_R, 1'b0);

    run_instr(32'h00500093, 0, 0, tr);            // addi x1,x0,5
    check("addi_retire_cycle", 64'(ret_cyc), 64'd4);
    check("addi_states", 64'({st_log[1], st_log[2], st_log[3], st_log[4]}),
          64'(12'b000_001_010_100));
    check("addi_reg_writes", 64'(rw_cnt), 64'd1);

    run_instr(32'h66208c23, 0, 2, tr);            // store, 2 memory wait cycles
    check("sw_retire_cycle", 64'(ret_cyc), 64'd6);
    check("sw_we_cycles", 64'(we_cnt), 64'd3);
    check("sw_reg_writes", 64'(rw_cnt), 64'd0);

    run_instr(32'ha1204883, 0, 0, tr);            // load
    check("lw_retire_cycle", 64'(ret_cyc), 64'd5);
    check("lw_wb_sel", 64'(rw_wb), 64'd1);

    cur_br = 1'b1;
    run_instr(32'h00000463, 0, 0, tr);            // beq taken
    check("beq_retire_cycle", 64'(ret_cyc), 64'd3);
    check("beq_taken_cycle", 64'(br_cyc), 64'd3);
    cur_br = 1'b0;
    run_instr(32'h00000463, 0, 0, tr);            // beq not taken
    check("beq_nt_taken_cycle", 64'(br_cyc), 64'd0);

    run_instr(32'h002081b3, 3, 0, tr);            // add with 3 fetch waits
    check("add_retire_cycle", 64'(ret_cyc), 64'd7);
    run_instr(32'h123450b7, 0, 0, tr);            // lui
    run_instr(32'h00001097, 0, 0, tr);            // auipc
    run_instr(32'h008000ef, 0, 0, tr);            // jal
    check("jal_retire_cycle", 64'(ret_cyc), 64'd3);
    cur_br = 1'b1;
    run_instr(32'h000080e7, 0, 0, tr);            // jalr, br_cond must be ignored
    cur_br = 1'b0;

    run_instr(32'h00000000, 0, 0, tr);            // illegal opcode
    for (int i = 0; i < 20; i++) step(PH_T, 1'($urandom_range(0, 1)));
    check("illegal_trap_cycle", 64'(trap_cyc), 64'd3);
    check("illegal_trap_held", 64'(trap_cnt), 64'd20);
    step(PH_R, 1'b1);
    run_instr(32'h00500093, 0, 0, tr);
    check("post_trap_retire", 64'(ret_cyc), 64'd4);

    run_instr(32'h00500093, 20, 0, tr);           // fetch never answered
    step(PH_T, 1'b0);
    step(PH_T, 1'b1);
    check("fetch_timeout_cycle", 64'(trap_cyc), 64'd16);
    step(PH_R, 1'b1);

    run_instr(32'ha1204883, 0, 20, tr);           // load data never answered
    step(PH_T, 1'b1);
    check("mem_timeout_cycle", 64'(trap_cyc), 64'd19);
    step(PH_R, 1'b1);

    cur_cyc = 0;                                  // reset while a load waits in MEM
    step(PH_F, 1'b1);
    instr = 32'ha1204883;
    step(PH_D, 1'b1);
    step(PH_E, 1'b1);
    step(PH_M, 1'b0);
    step(PH_M, 1'b0);
    step(PH_R, 1'b0);
    check("abort_reg_writes", 64'(rw_cnt), 64'd0);
    check("abort_retire", 64'(ret_cyc), 64'd0);
    run_instr(32'h00500093, 14, 0, tr);           // wait counter must restart from zero
    check("abort_restart_retire", 64'(ret_cyc), 64'd18);

`ifdef MULTICYCLE_CTRL_PERF_EN
    step(PH_R, 1'b1);
    for (int i = 0; i < 3; i++) run_instr(32'h00500093, 0, 0, tr);
    check("perf_instret", 64'(instret_cnt), 64'd3);
    check("perf_cycles", 64'(cycle_cnt), 64'd12);
`endif

    exp_vld = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
